// File: rtl/beamformer_pkg.sv
// Shared definitions for the fullbeamformer control path: the control-state
// codes driven on ext_next_control_state and the sequencer FSM encoding.
package beamformer_pkg;

  localparam int DEF_SUM_W = 36;

  localparam logic [2:0] CS_LOADIN      = 3'd0;
  localparam logic [2:0] CS_FILTERING   = 3'd1;
  localparam logic [2:0] CS_FINISHFILT  = 3'd2;
  localparam logic [2:0] CS_BEAMFORMING = 3'd3;
  localparam logic [2:0] CS_SUMMING     = 3'd4;
  localparam logic [2:0] CS_DONE        = 3'd5;

  typedef enum logic [2:0] {
    SQ_IDLE,
    SQ_LOAD,
    SQ_FILT,
    SQ_FLUSH,
    SQ_BEAM,
    SQ_SUM,
    SQ_DONE
  } seq_state_e;

endpackage

// File: rtl/phase_dwell_counter.sv
// Down-counter that times how long the sequencer stays in one phase.
// Loaded with (dwell-1) on phase entry; zero_o marks the last cycle.
module phase_dwell_counter
  import beamformer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load has priority; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                     cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/beamformer_sequencer.sv
// Steps the fullbeamformer through its control phases with fixed dwell
// counts, captures summed_value at the end of DONE and offers it on a
// valid/ready port.
module beamformer_sequencer
  import beamformer_pkg::*;
#(
  parameter int LOAD_CYCLES  = 8,
  parameter int FILT_CYCLES  = 64,
  parameter int FLUSH_CYCLES = 4,
  parameter int BEAM_CYCLES  = 16,
  parameter int SUM_CYCLES   = 8,
  parameter int CAPTURE_LAT  = 2,
  parameter int SUM_W        = DEF_SUM_W,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic [2:0]       next_control_state,
  input  logic [SUM_W-1:0] summed_value,
  output logic [SUM_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             overrun,
  output logic [15:0]      frame_count
);

  seq_state_e       state_q, adv_state;
  logic [2:0]       cs_q, adv_cs;
  logic [CNT_W-1:0] adv_len, cnt_val;
  logic             cnt_ld, cnt_dec, cnt_zero;
  logic             busy_q, rv_q, ovr_q;
  logic [SUM_W-1:0] result_q;
  logic [15:0]      fc_q;

  // Successor of the current phase: state, control code and dwell reload.
  always_comb begin
    adv_state = SQ_IDLE;
    adv_cs    = CS_LOADIN;
    adv_len   = '0;
    case (state_q)
      SQ_LOAD:  begin adv_state = SQ_FILT;  adv_cs = CS_FILTERING;   adv_len = CNT_W'(FILT_CYCLES - 1);  end
      SQ_FILT:  begin adv_state = SQ_FLUSH; adv_cs = CS_FINISHFILT;  adv_len = CNT_W'(FLUSH_CYCLES - 1); end
      SQ_FLUSH: begin adv_state = SQ_BEAM;  adv_cs = CS_BEAMFORMING; adv_len = CNT_W'(BEAM_CYCLES - 1);  end
      SQ_BEAM:  begin adv_state = SQ_SUM;   adv_cs = CS_SUMMING;     adv_len = CNT_W'(SUM_CYCLES - 1);   end
      SQ_SUM:   begin adv_state = SQ_DONE;  adv_cs = CS_DONE;        adv_len = CNT_W'(CAPTURE_LAT);      end
      default:  ;
    endcase
  end

  // Dwell counter control: load on frame start / phase change, clear on abort.
  always_comb begin
    cnt_ld  = 1'b0;
    cnt_val = '0;
    cnt_dec = 1'b0;
    if (state_q == SQ_IDLE) begin
      cnt_ld  = start;
      cnt_val = CNT_W'(LOAD_CYCLES - 1);
    end else if (abort) begin
      cnt_ld  = 1'b1;
    end else if (cnt_zero) begin
      cnt_ld  = 1'b1;
      cnt_val = adv_len;
    end else begin
      cnt_dec = 1'b1;
    end
  end

  phase_dwell_counter #(.CNT_W(CNT_W)) u_dwell (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_ld),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // Sequencer FSM with registered control outputs and result capture.
  // Abort outranks both the dwell advance and the DONE capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SQ_IDLE;
      cs_q     <= CS_LOADIN;
      busy_q   <= 1'b0;
      result_q <= '0;
      rv_q     <= 1'b0;
      ovr_q    <= 1'b0;
      fc_q     <= '0;
    end else begin
      if (rv_q && result_ready) rv_q <= 1'b0;
      if (state_q == SQ_IDLE) begin
        if (start) begin
          state_q <= SQ_LOAD;
          cs_q    <= CS_LOADIN;
          busy_q  <= 1'b1;
        end
      end else if (abort) begin
        state_q <= SQ_IDLE;
        cs_q    <= CS_LOADIN;
        busy_q  <= 1'b0;
      end else if (cnt_zero) begin
        state_q <= adv_state;
        cs_q    <= adv_cs;
        if (state_q == SQ_DONE) begin
          busy_q   <= 1'b0;
          result_q <= summed_value;
          rv_q     <= 1'b1;
          fc_q     <= fc_q + 16'd1;
          if (rv_q && !result_ready) ovr_q <= 1'b1;
        end
      end
    end
  end

  assign busy               = busy_q;
  assign next_control_state = cs_q;
  assign result             = result_q;
  assign result_valid       = rv_q;
  assign overrun            = ovr_q;
  assign frame_count        = fc_q;

endmodule

// File: tb/tb_beamformer_sequencer.sv
// Bench for beamformer_sequencer: per-cycle phase checks against a phase
// length table, and a result scoreboard popped on each accepted handshake.
module tb_beamformer_sequencer;
  import beamformer_pkg::*;

  localparam int L = 8, F = 64, FLS = 4, B = 16, S = 8, CL = 2, SW = 36;
  localparam int FL = 1 + L + F + FLS + B + S + CL + 1;   // start edge .. busy-low edge

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, rdy = 1'b0;
  logic [SW-1:0] sv = '0;
  logic busy, rv, ovr;
  logic [2:0] ncs;
  logic [SW-1:0] res;
  logic [15:0] fc;

  logic m_start = 1'b0, m_abort = 1'b0, m_rdy = 1'b0;
  logic [SW-1:0] m_sv = '0;
  logic m_busy, m_rv, m_ovr;
  logic [2:0] m_ncs;
  logic [SW-1:0] m_res;
  logic [15:0] m_fc;

  always #5 clk = ~clk;

  beamformer_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy),
    .next_control_state(ncs), .summed_value(sv), .result(res),
    .result_valid(rv), .result_ready(rdy), .overrun(ovr), .frame_count(fc)
  );

  beamformer_sequencer #(
    .LOAD_CYCLES(1), .FILT_CYCLES(1), .FLUSH_CYCLES(1), .BEAM_CYCLES(1),
    .SUM_CYCLES(1), .CAPTURE_LAT(0)
  ) u_min (
    .clk(clk), .rst_n(rst_n), .start(m_start), .abort(m_abort), .busy(m_busy),
    .next_control_state(m_ncs), .summed_value(m_sv), .result(m_res),
    .result_valid(m_rv), .result_ready(m_rdy), .overrun(m_ovr), .frame_count(m_fc)
  );

  int n_vec = 0, n_err = 0;
  bit mon_en = 1'b0;
  logic [SW-1:0] exp_q[$];
  logic [15:0]   exp_fc = '0;
  bit            exp_ovr = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Control code expected j cycles after the start edge (1 .. FL-1).
  function automatic int exp_phase(input int j);
    int lens[6];
    int rem;
    lens = '{L, F, FLS, B, S, CL + 1};
    rem = j - 1;
    for (int p = 0; p < 6; p++) begin
      if (rem < lens[p]) return p;
      rem -= lens[p];
    end
    return 0;
  endfunction

  // Monitor: result port against the scoreboard every cycle.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      chk("result_valid", rv, exp_q.size() > 0);
      chk("overrun", ovr, exp_ovr);
      chk("frame_count", fc, exp_fc);
      if (exp_q.size() > 0) begin
        chk("result", res, exp_q[0]);
        if (rdy) void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive_rdy(input int rmode);
    rdy = (rmode == 2) ? 1'($urandom_range(0, 1)) : (rmode == 1);
  endtask

  task automatic idle(input int n, input int rmode, input bit rnd_abort);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #2;
      start = 1'b0;
      abort = rnd_abort ? 1'($urandom_range(0, 1)) : 1'b0;
      drive_rdy(rmode);
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_ncs", ncs, CS_LOADIN);
    end
    abort = 1'b0;
  endtask

  task automatic run_frame(input int abort_at, input int rst_at, input int rmode,
                           input bit dup, input bit sab, input bit use_fix,
                           input logic [SW-1:0] fixv);
    logic [SW-1:0] cap;
    bit ab;
    cap = '0;
    for (int j = 0; j <= FL; j++) begin
      @(posedge clk); #2;
      ab = (abort_at > 0) && (j > abort_at);
      start = (j == 0) || (dup && j == 40);
      abort = ((abort_at > 0) && (j == abort_at)) || (sab && j == 0);
      drive_rdy(rmode);
      sv = SW'({$urandom(), $urandom()});
      if (j == FL - 1) begin
        if (use_fix) sv = fixv;
        cap = sv;
      end
      if (j == FL && !ab) begin
        if (exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          exp_ovr = 1'b1;
        end
        exp_q.push_back(cap);
        exp_fc++;
      end
      if (rst_at > 0 && j == rst_at) begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        exp_q.delete();
        exp_fc = '0;
        exp_ovr = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ncs", ncs, CS_LOADIN);
        chk("rst_result", res, 0);
        chk("rst_valid", rv, 0);
        chk("rst_overrun", ovr, 0);
        chk("rst_fc", fc, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        return;
      end
      @(negedge clk);
      if (j == 0 || j >= FL || ab) begin
        chk("busy", busy, 0);
        chk("ncs", ncs, CS_LOADIN);
      end else begin
        chk("busy", busy, 1);
        chk("ncs", ncs, exp_phase(j));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    logic [SW-1:0] mcap;
    mcap = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("por_busy", busy, 0);
    chk("por_ncs", ncs, CS_LOADIN);
    chk("por_result", res, 0);
    chk("por_valid", rv, 0);
    chk("por_overrun", ovr, 0);
    chk("por_fc", fc, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    idle(4, 1, 1'b1);                                    // abort in IDLE is a no-op

    run_frame(0, 0, 1, 1'b0, 1'b0, 1'b0, '0);            // default frame
    run_frame(0, 0, 1, 1'b0, 1'b0, 1'b1, 36'h8_0000_0001);
    idle(2, 1, 1'b0);

    run_frame(0, 0, 0, 1'b0, 1'b0, 1'b1, 36'd5);         // unconsumed result ...
    run_frame(0, 0, 0, 1'b0, 1'b0, 1'b1, 36'd9);         // ... overwritten
    idle(3, 0, 1'b0);
    chk("ovr_result", res, 36'd9);
    chk("ovr_flag", ovr, 1);
    chk("ovr_fc", fc, 4);
    idle(2, 1, 1'b0);

    run_frame(L + 10, 0, 1, 1'b0, 1'b0, 1'b0, '0);       // abort in FILT cycle 10
    idle(2, 1, 1'b0);
    chk("abort_fc", fc, 4);
    run_frame(0, 0, 1, 1'b0, 1'b0, 1'b0, '0);
    run_frame(0, 0, 1, 1'b0, 1'b1, 1'b0, '0);            // start+abort in IDLE

    run_frame(0, L + F + FLS + 5, 1, 1'b0, 1'b0, 1'b0, '0); // reset during BEAM
    idle(2, 1, 1'b0);
    run_frame(0, 0, 1, 1'b1, 1'b0, 1'b0, '0);            // start while busy ignored

    for (int k = 0; k < 5; k++) begin
      run_frame(0, 0, 2, 1'b0, 1'b0, 1'b0, '0);
      idle($urandom_range(0, 3), 2, 1'b0);
    end
    idle(3, 1, 1'b0);

    // Minimum-dwell instance: one cycle per phase, capture in the only DONE cycle.
    for (int j = 0; j <= 7; j++) begin
      @(posedge clk); #2;
      m_start = (j == 0);
      m_sv = SW'({$urandom(), $urandom()});
      if (j == 6) mcap = m_sv;
      @(negedge clk);
      chk("min_busy", m_busy, (j >= 1 && j <= 6));
      chk("min_ncs", m_ncs, (j >= 1 && j <= 6) ? j - 1 : 0);
      chk("min_valid", m_rv, (j == 7));
    end
    chk("min_result", m_res, mcap);
    chk("min_fc", m_fc, 1);
    chk("min_overrun", m_ovr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
